// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell reused LSB first,
// with a registered borrow. Operands are captured on an IDLE handshake and the
// result is held in DONE until the consumer takes it.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             borrow_out_q;

  logic             d_d;
  logic             br_d;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  always_comb begin
    d_d  = a_q[0] ^ b_q[0] ^ br_q;
    br_d = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  end

  // Control FSM and datapath: capture, shift one bit per cycle, hold result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      br_q         <= 1'b0;
      cnt_q        <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      borrow_out_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // in_ready comes up one edge after reset release and stays up in IDLE.
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            br_q       <= borrow_in;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          // Each new bit enters at the MSB, so bit i reaches diff[i] after WIDTH shifts.
          res_q <= {d_d, res_q[WIDTH-1:1]};
          if (cnt_q == LAST_BIT) begin
            borrow_out_q <= br_d;
            out_valid_q  <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign diff       = res_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three instances (WIDTH 8, 2, 16) share one clock
// and reset. A queue-based arithmetic model predicts every result at accept
// time; a per-cycle compare step checks results, stalls and latency.
module tb_serial_subtractor;

  logic        clk;
  logic        rst;
  logic [2:0]  iv;
  logic [2:0]  ir;
  logic [2:0]  bi;
  logic [2:0]  ov;
  logic [2:0]  ordy;
  logic [2:0]  bo;
  logic [15:0] a_s    [3];
  logic [15:0] b_s    [3];
  logic [15:0] diff_s [3];

  int unsigned n_cmp;
  int unsigned n_fail;
  int unsigned cyc;

  logic [16:0] expq [3][$];
  int unsigned done_cnt [3];
  int unsigned acc_cyc  [3];
  logic        held_v   [3];
  logic [15:0] held_d   [3];
  logic        held_bo  [3];
  logic        last_ov  [3];

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int unsigned W = (g == 0) ? 8 : ((g == 1) ? 2 : 16);
    logic [W-1:0] dw;
    serial_subtractor #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .a         (a_s[g][W-1:0]),
      .b         (b_s[g][W-1:0]),
      .borrow_in (bi[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .diff      (dw),
      .borrow_out(bo[g])
    );
    assign diff_s[g] = 16'(dw);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned lw(input int l);
    return (l == 0) ? 8 : ((l == 1) ? 2 : 16);
  endfunction

  function automatic logic [15:0] lmask(input int l);
    return 16'((32'd1 << lw(l)) - 32'd1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    for (int l = 0; l < 3; l++) begin
      expq[l].delete();
      held_v[l]  = 1'b0;
      last_ov[l] = 1'b0;
    end
  endtask

  // Called at a negedge after inputs are driven: checks outputs, records handshakes.
  task automatic compare_cycle();
    int unsigned av, bv, dv;
    logic        bov;
    logic [16:0] e;
    for (int l = 0; l < 3; l++) begin
      if (held_v[l]) begin
        chk($sformatf("L%0d_stall_valid", l), 32'(ov[l]), 32'd1);
        chk($sformatf("L%0d_stall_diff", l), 32'(diff_s[l]), 32'(held_d[l]));
        chk($sformatf("L%0d_stall_bo", l), 32'(bo[l]), 32'(held_bo[l]));
        chk($sformatf("L%0d_stall_inrdy", l), 32'(ir[l]), 32'd0);
      end
      if (ov[l] && !last_ov[l])
        chk($sformatf("L%0d_latency", l), cyc - acc_cyc[l], lw(l));
      if (ov[l] && ordy[l]) begin
        if (expq[l].size() == 0) begin
          chk($sformatf("L%0d_unexpected_result", l), 32'd1, 32'd0);
        end else begin
          e = expq[l].pop_front();
          chk($sformatf("L%0d_diff", l), 32'(diff_s[l]), 32'(e[15:0]));
          chk($sformatf("L%0d_borrow_out", l), 32'(bo[l]), 32'(e[16]));
          done_cnt[l]++;
        end
      end
      if (iv[l] && ir[l]) begin
        chk($sformatf("L%0d_accept_while_busy", l), expq[l].size(), 32'd0);
        av  = 32'(a_s[l] & lmask(l));
        bv  = 32'(b_s[l] & lmask(l));
        dv  = (av - bv - 32'(bi[l])) & 32'(lmask(l));
        bov = (av < bv + 32'(bi[l]));
        expq[l].push_back({bov, 16'(dv)});
        acc_cyc[l] = cyc + 1;
      end
      held_v[l]  = ov[l] && !ordy[l];
      held_d[l]  = diff_s[l];
      held_bo[l] = bo[l];
      last_ov[l] = ov[l];
    end
  endtask

  task automatic tick();
    compare_cycle();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Reset asserted at a negedge, checked immediately, released two cycles later.
  task automatic do_reset(input string nm);
    rst = 1'b1;
    #1;
    chk({nm, "_out_valid"}, 32'(ov[0]), 32'd0);
    chk({nm, "_in_ready"}, 32'(ir[0]), 32'd0);
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    chk({nm, "_in_ready_after"}, 32'(ir[0]), 32'd1);
  endtask

  // One WIDTH=8 operation on lane 0 with literal expectations; optional backpressure.
  task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic bin,
                         input logic [7:0] ed, input logic eb, input logic hold,
                         input string nm);
    int n;
    logic [15:0] d0;
    logic        b0;
    a_s[0] = 16'(av); b_s[0] = 16'(bv); bi[0] = bin; iv[0] = 1'b1;
    ordy[0] = !hold;
    n = 0;
    while (!ir[0] && n < 40) begin tick(); n++; end
    chk({nm, "_in_ready"}, 32'(ir[0]), 32'd1);
    tick();
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 40) begin
      a_s[0] = 16'($urandom_range(0, 255));
      b_s[0] = 16'($urandom_range(0, 255));
      bi[0]  = 1'($urandom_range(0, 1));
      iv[0]  = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    iv[0] = 1'b0;
    chk({nm, "_cycles_to_valid"}, 32'(n), 32'd8);
    chk({nm, "_diff"}, 32'(diff_s[0]), 32'(ed));
    chk({nm, "_borrow"}, 32'(bo[0]), 32'(eb));
    if (hold) begin
      d0 = diff_s[0]; b0 = bo[0];
      for (int k = 0; k < 5; k++) begin
        a_s[0] = 16'($urandom_range(0, 255));
        iv[0]  = 1'b1;
        tick();
        chk({nm, "_hold_valid"}, 32'(ov[0]), 32'd1);
        chk({nm, "_hold_diff"}, 32'(diff_s[0]), 32'(d0));
        chk({nm, "_hold_borrow"}, 32'(bo[0]), 32'(b0));
        chk({nm, "_hold_in_ready"}, 32'(ir[0]), 32'd0);
      end
      iv[0] = 1'b0;
      ordy[0] = 1'b1;
    end
    tick();
    chk({nm, "_consumed"}, 32'(ov[0]), 32'd0);
  endtask

  initial begin
    int guard;
    n_cmp = 0; n_fail = 0; cyc = 0;
    rst = 1'b1; iv = '0; bi = '0; ordy = '1;
    for (int l = 0; l < 3; l++) begin
      a_s[l] = '0; b_s[l] = '0; done_cnt[l] = 0; acc_cyc[l] = 0;
    end
    clear_model();

    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(ov[0]), 32'd0);
    chk("reset_diff", 32'(diff_s[0]), 32'd0);
    chk("reset_borrow", 32'(bo[0]), 32'd0);
    chk("reset_in_ready", 32'(ir[0]), 32'd0);
    rst = 1'b0;
    tick();
    chk("release_in_ready", 32'(ir[0]), 32'd1);

    run_op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "t1");
    run_op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "t2a");
    run_op8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b0, "t2b");
    run_op8(8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b1, 1'b0, "t3a");
    run_op8(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, "t3b");
    run_op8(8'h3C, 8'hA5, 1'b0, 8'h97, 1'b1, 1'b1, "t4");

    // Reset during the third RUN cycle.
    a_s[0] = 16'h00AA; b_s[0] = 16'h0011; bi[0] = 1'b0; iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    tick(); tick();
    do_reset("t5_run");
    run_op8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, "t5_next");

    // Reset while a result waits in DONE.
    a_s[0] = 16'h0033; b_s[0] = 16'h0022; bi[0] = 1'b0; iv[0] = 1'b1; ordy[0] = 1'b0;
    tick();
    iv[0] = 1'b0;
    guard = 0;
    while (!ov[0] && guard < 40) begin tick(); guard++; end
    chk("t5_done_valid", 32'(ov[0]), 32'd1);
    do_reset("t5_done");
    ordy[0] = 1'b1;

    // Randomised traffic on all three lanes.
    for (int l = 0; l < 3; l++) done_cnt[l] = 0;
    guard = 0;
    while ((done_cnt[1] < 1000 || done_cnt[2] < 1000) && guard < 60000) begin
      for (int l = 0; l < 3; l++) begin
        iv[l]   = ($urandom_range(0, 3) != 0);
        a_s[l]  = 16'($urandom) & lmask(l);
        b_s[l]  = 16'($urandom) & lmask(l);
        bi[l]   = 1'($urandom_range(0, 1));
        ordy[l] = ($urandom_range(0, 3) != 0);
      end
      tick();
      guard++;
    end
    chk("random_ops_completed", 32'(done_cnt[1] >= 1000 && done_cnt[2] >= 1000), 32'd1);

    iv = '0; ordy = '1;
    repeat (40) tick();
    for (int l = 0; l < 3; l++)
      chk($sformatf("L%0d_results_outstanding", l), expq[l].size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
